sram_arb: RTL and testbench
===========================

SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, extra SRAM cycles per access; legal range 0..15.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-004 cpu_ad  in  16  CPU address.
REQ-005 cpu_di  in  8  CPU write data.
REQ-006 cpu_do  out  8  CPU read data, registered.
REQ-007 cpu_rw  in  1  1 = read, 0 = write.
REQ-008 cpu_cs  in  1  CPU access request; held with ad/di/rw until cpu_ready.
REQ-009 cpu_ready  out  1  CPU may advance.
REQ-010 dma_ad  in  16  DMA address.
REQ-011 dma_di  in  8  DMA write data.
REQ-012 dma_do  out  8  DMA read data, registered.
REQ-013 dma_rw  in  1  1 = read, 0 = write.
REQ-014 dma_req  in  1  DMA access request; held until dma_ack.
REQ-015 dma_ack  out  1  one-cycle completion pulse.
REQ-016 mem_ad  out  16  address to SRAM stage.
REQ-017 mem_di  out  8  write data to SRAM stage.
REQ-018 mem_do  in  8  read data from SRAM stage.
REQ-019 mem_rw  out  1  to SRAM stage; 1 = read.
REQ-020 mem_cs  out  1  to SRAM stage chip select.

Function
REQ-021 FSM states IDLE, ACCESS, DONE; owner flag (CPU/DMA); last-grant flag; 4-bit down-counter.
REQ-022 IDLE: no request -> stay; one requester -> grant it; both -> grant the one not granted last (round-robin); first contention after reset -> CPU.
REQ-023 On grant: latch requester ad/di/rw into registers, load counter = WAIT_CYCLES, set owner, update last-grant, go ACCESS next cycle.
REQ-024 ACCESS: mem_cs = 1, mem_ad/mem_di/mem_rw from latched registers, stable for all WAIT_CYCLES+1 cycles.
REQ-025 ACCESS: counter != 0 -> decrement, stay; counter == 0 -> capture mem_do into owner's read register if read, go DONE.
REQ-026 Write access: owner's read-data register unchanged.
REQ-027 DONE (exactly one cycle): mem_cs = 0, mem_rw = 1; owner CPU -> cpu_ready = 1; owner DMA -> dma_ack = 1; next state IDLE.
REQ-028 Outside ACCESS: mem_cs = 0, mem_rw = 1, mem_ad/mem_di hold last latched values.
REQ-029 cpu_ready = 1 when cpu_cs = 0, or DONE with owner CPU; 0 otherwise.
REQ-030 dma_ack = 1 only in DONE with owner DMA.
REQ-031 Latency: request sampled in IDLE at edge N -> ready/ack high during cycle N+WAIT_CYCLES+2; back-to-back same requester: one access per WAIT_CYCLES+3 cycles.
REQ-032 Requester deasserting mid-access: access completes, DONE still pulses, no abort.
REQ-033 Request arriving during ACCESS/DONE: waits; evaluated in next IDLE.
REQ-034 Request held across DONE not re-served: CPU/DMA must present new transfer in IDLE cycle after ready/ack; IDLE samples only then.
REQ-035 Addresses 16-bit, no wrap or translation; address passes unmodified.

Reset
REQ-036 rst high at edge -> IDLE, mem_cs = 0, mem_rw = 1, mem_ad = 0, mem_di = 0, cpu_do = 0, dma_do = 0, dma_ack = 0, counter = 0, last-grant = DMA (so CPU wins first tie).
REQ-037 rst mid-ACCESS: access abandoned, no ready/ack pulse, no read-data update; rst has priority over all transitions.

Verification
REQ-038 WAIT_CYCLES=1, CPU read 0x1234, mem_do = 0xA5 -> mem_cs high 2 cycles, cpu_ready high cycle N+3, cpu_do = 0xA5.
REQ-039 DMA write 0x8000 data 0x3C -> mem_rw = 0, mem_ad = 0x8000, mem_di = 0x3C for 2 cycles; single dma_ack pulse; dma_do unchanged.
REQ-040 cpu_cs and dma_req together, both held -> CPU, DMA, CPU grants alternate; never two grants to one requester while other waits.
REQ-041 WAIT_CYCLES=0, CPU read -> mem_cs 1 cycle, cpu_ready at N+2.
REQ-042 rst during second ACCESS cycle -> mem_cs 0 next cycle, no cpu_ready/dma_ack pulse, cpu_do = 0.
REQ-043 dma_req dropped during ACCESS -> access completes, dma_ack still pulses once, FSM returns IDLE.

Source files
------------

// File: rtl/sram_arb.sv
// ---------------------------------------------------------------------------
// sram_arb
//
// Purpose:
//   Arbitrates a CPU port and a DMA port onto a single SRAM stage. When both
//   ports request in the same idle cycle, the grant alternates between them
//   (round-robin). On a grant the winner's address, write data and direction
//   are latched. The latched values drive the SRAM for WAIT_CYCLES+1 cycles,
//   followed by a one-cycle completion phase. Read data is captured into a
//   per-requester register.
//
// Parameters:
//   WAIT_CYCLES  extra SRAM cycles per access (0..15)
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   cpu_ad     CPU address            cpu_di     CPU write data
//   cpu_rw     CPU direction (1=read) cpu_cs     CPU request, held until ready
//   cpu_do     CPU read data (reg)    cpu_ready  CPU may advance
//   dma_ad     DMA address            dma_di     DMA write data
//   dma_rw     DMA direction (1=read) dma_req    DMA request, held until ack
//   dma_do     DMA read data (reg)    dma_ack    one-cycle completion pulse
//   mem_ad     SRAM address           mem_di     SRAM write data
//   mem_do     SRAM read data         mem_rw     SRAM direction (1=read)
//   mem_cs     SRAM chip select
// ---------------------------------------------------------------------------
module sram_arb #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_ad,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    input  logic        cpu_rw,
    input  logic        cpu_cs,
    output logic        cpu_ready,
    input  logic [15:0] dma_ad,
    input  logic [7:0]  dma_di,
    output logic [7:0]  dma_do,
    input  logic        dma_rw,
    input  logic        dma_req,
    output logic        dma_ack,
    output logic [15:0] mem_ad,
    output logic [7:0]  mem_di,
    input  logic [7:0]  mem_do,
    output logic        mem_rw,
    output logic        mem_cs
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    state_t      state_q,  state_d;
    owner_t      owner_q,  owner_d;
    owner_t      last_q,   last_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [15:0] ad_q,     ad_d;
    logic [7:0]  di_q,     di_d;
    logic        rw_q,     rw_d;
    logic [7:0]  cpu_do_q, cpu_do_d;
    logic [7:0]  dma_do_q, dma_do_d;

    // On a tie the port that did not win last time gets the grant. Both
    // terms can never be true together, so the CPU branch below has no
    // hidden priority.
    logic grant_cpu;
    logic grant_dma;
    assign grant_cpu = cpu_cs  && (!dma_req || (last_q == OWN_DMA));
    assign grant_dma = dma_req && (!cpu_cs  || (last_q == OWN_CPU));

    always_comb begin
        // NOTE: every next-state variable takes its held value first, so no
        // path through the case statement can leave one unassigned and infer
        // a latch.
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        ad_d     = ad_q;
        di_d     = di_q;
        rw_d     = rw_q;
        cpu_do_d = cpu_do_q;
        dma_do_d = dma_do_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_cpu) begin
                    ad_d    = cpu_ad;
                    di_d    = cpu_di;
                    rw_d    = cpu_rw;
                    owner_d = OWN_CPU;
                    last_d  = OWN_CPU;
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_ACCESS;
                end else if (grant_dma) begin
                    ad_d    = dma_ad;
                    di_d    = dma_di;
                    rw_d    = dma_rw;
                    owner_d = OWN_DMA;
                    last_d  = OWN_DMA;
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // The SRAM data is valid on the last access cycle. A write
                    // leaves both read registers untouched.
                    if (rw_q) begin
                        if (owner_q == OWN_DMA) begin
                            dma_do_d = mem_do;
                        end else begin
                            cpu_do_d = mem_do;
                        end
                    end
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // The completion phase does not sample requests. A requester
                // still asserting here is seen again only in the next idle
                // cycle.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the latched address/data and both read registers are reset along
    // with the control state, because their values are visible on output
    // ports straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments, so every
            // flop samples the pre-edge values and no ordering races occur
            // between blocks.
            state_q  <= ST_IDLE;
            owner_q  <= OWN_CPU;
            last_q   <= OWN_DMA;
            cnt_q    <= 4'd0;
            ad_q     <= 16'h0000;
            di_q     <= 8'h00;
            rw_q     <= 1'b1;
            cpu_do_q <= 8'h00;
            dma_do_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            ad_q     <= ad_d;
            di_q     <= di_d;
            rw_q     <= rw_d;
            cpu_do_q <= cpu_do_d;
            dma_do_q <= dma_do_d;
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free.
    // The exception is cpu_ready, which also passes an idle CPU (cpu_cs low).
    assign mem_cs    = (state_q == ST_ACCESS);
    assign mem_rw    = (state_q == ST_ACCESS) ? rw_q : 1'b1;
    assign mem_ad    = ad_q;
    assign mem_di    = di_q;
    assign cpu_do    = cpu_do_q;
    assign dma_do    = dma_do_q;
    assign cpu_ready = !cpu_cs || ((state_q == ST_DONE) && (owner_q == OWN_CPU));
    assign dma_ack   = (state_q == ST_DONE) && (owner_q == OWN_DMA);

endmodule

// File: tb/tb_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_sram_arb
//
// Bench for sram_arb. One instance uses WAIT_CYCLES=1 and carries most of
// the tests. A second instance uses WAIT_CYCLES=0 and shares the same inputs.
// The SRAM stage is modelled as a fixed function of the address.
// ---------------------------------------------------------------------------
module tb_sram_arb;

    localparam int unsigned W = 1;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_ad;
    logic [7:0]  cpu_di;
    logic        cpu_rw;
    logic        cpu_cs;
    logic [15:0] dma_ad;
    logic [7:0]  dma_di;
    logic        dma_rw;
    logic        dma_req;

    logic [7:0]  cpu_do,  dma_do,  mem_di,  mem_do;
    logic [15:0] mem_ad;
    logic        cpu_ready, dma_ack, mem_rw, mem_cs;

    logic [7:0]  cpu_do0, dma_do0, mem_di0, mem_do0;
    logic [15:0] mem_ad0;
    logic        cpu_ready0, dma_ack0, mem_rw0, mem_cs0;

    logic        ovr_en;
    logic [7:0]  ovr_val;

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always_comb mem_do  = ovr_en ? ovr_val : mem_fn(mem_ad);
    always_comb mem_do0 = mem_fn(mem_ad0);

    sram_arb #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .cpu_ad(cpu_ad), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_rw(cpu_rw),
        .cpu_cs(cpu_cs), .cpu_ready(cpu_ready),
        .dma_ad(dma_ad), .dma_di(dma_di), .dma_do(dma_do), .dma_rw(dma_rw),
        .dma_req(dma_req), .dma_ack(dma_ack),
        .mem_ad(mem_ad), .mem_di(mem_di), .mem_do(mem_do), .mem_rw(mem_rw),
        .mem_cs(mem_cs)
    );

    sram_arb #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_ad(cpu_ad), .cpu_di(cpu_di), .cpu_do(cpu_do0), .cpu_rw(cpu_rw),
        .cpu_cs(cpu_cs), .cpu_ready(cpu_ready0),
        .dma_ad(dma_ad), .dma_di(dma_di), .dma_do(dma_do0), .dma_rw(dma_rw),
        .dma_req(dma_req), .dma_ack(dma_ack0),
        .mem_ad(mem_ad0), .mem_di(mem_di0), .mem_do(mem_do0), .mem_rw(mem_rw0),
        .mem_cs(mem_cs0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_ad = 16'h0; cpu_di = 8'h0;
        dma_req = 1'b0; dma_rw = 1'b1; dma_ad = 16'h0; dma_di = 8'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ----------------------------------------------------------------------
    // Table-driven vectors (WAIT_CYCLES=1). Inputs are applied before an edge;
    // outputs are compared 1 time unit after that edge.
    // ----------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        ccs;
        logic        crw;
        logic [15:0] cad;
        logic [7:0]  cdi;
        logic        dreq;
        logic        drw;
        logic [15:0] dad;
        logic [7:0]  ddi;
        logic [7:0]  mdo;
        logic        mcs;
        logic        mrw;
        logic [15:0] mad;
        logic [7:0]  mdi;
        logic        rdy;
        logic        ack;
        logic [7:0]  cdo;
        logic [7:0]  ddo;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    task automatic fill_table();
        // CPU read 0x1234 returning 0xA5
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h00,
                    1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h00,
                    1'b1, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 8'hA5,
                    1'b1, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 8'hA5,
                    1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b0, 8'hA5, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h00,
                    1'b0, 1'b1, 16'h1234, 8'h00, 1'b1, 1'b0, 8'hA5, 8'h00};
        // DMA write 0x8000 <- 0x3C; SRAM returns junk that must not be captured
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h8000, 8'h3C, 8'h77,
                    1'b1, 1'b0, 16'h8000, 8'h3C, 1'b1, 1'b0, 8'hA5, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h8000, 8'h3C, 8'h77,
                    1'b1, 1'b0, 16'h8000, 8'h3C, 1'b1, 1'b0, 8'hA5, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h8000, 8'h3C, 8'h77,
                    1'b0, 1'b1, 16'h8000, 8'h3C, 1'b1, 1'b1, 8'hA5, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h8000, 8'h3C, 8'h77,
                    1'b0, 1'b1, 16'h8000, 8'h3C, 1'b1, 1'b0, 8'hA5, 8'h00};
        // Both held: CPU (last grant was DMA), then DMA, then CPU
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b1, 1'b0, 16'h0001, 8'h11, 1'b0, 1'b0, 8'hA5, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b1, 1'b0, 16'h0001, 8'h11, 1'b0, 1'b0, 8'hA5, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b0, 1'b1, 16'h0001, 8'h11, 1'b1, 1'b0, 8'hA5, 8'h00};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b0, 1'b1, 16'h0001, 8'h11, 1'b0, 1'b0, 8'hA5, 8'h00};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b1, 1'b0, 16'h0002, 8'h22, 1'b0, 1'b0, 8'hA5, 8'h00};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b1, 1'b0, 16'h0002, 8'h22, 1'b0, 1'b0, 8'hA5, 8'h00};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b0, 1'b1, 16'h0002, 8'h22, 1'b0, 1'b1, 8'hA5, 8'h00};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b0, 1'b1, 16'h0002, 8'h22, 1'b0, 1'b0, 8'hA5, 8'h00};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b1, 1'b0, 16'h0001, 8'h11, 1'b0, 1'b0, 8'hA5, 8'h00};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b1, 1'b0, 16'h0001, 8'h11, 1'b0, 1'b0, 8'hA5, 8'h00};
        // Reset during the second access cycle: abandoned, everything cleared
        tbl[19] = '{1'b1, 1'b1, 1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'h0002, 8'h22, 8'h00,
                    1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h00,
                    1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00};
    endtask

    task automatic run_table();
        ovr_en = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            rst     = tbl[i].rst;
            cpu_cs  = tbl[i].ccs;  cpu_rw = tbl[i].crw; cpu_ad = tbl[i].cad; cpu_di = tbl[i].cdi;
            dma_req = tbl[i].dreq; dma_rw = tbl[i].drw; dma_ad = tbl[i].dad; dma_di = tbl[i].ddi;
            ovr_val = tbl[i].mdo;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d mem_cs", i),    32'(mem_cs),    32'(tbl[i].mcs));
            check($sformatf("vec%0d mem_rw", i),    32'(mem_rw),    32'(tbl[i].mrw));
            check($sformatf("vec%0d mem_ad", i),    32'(mem_ad),    32'(tbl[i].mad));
            check($sformatf("vec%0d mem_di", i),    32'(mem_di),    32'(tbl[i].mdi));
            check($sformatf("vec%0d cpu_ready", i), 32'(cpu_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d dma_ack", i),   32'(dma_ack),   32'(tbl[i].ack));
            check($sformatf("vec%0d cpu_do", i),    32'(cpu_do),    32'(tbl[i].cdo));
            check($sformatf("vec%0d dma_do", i),    32'(dma_do),    32'(tbl[i].ddo));
        end
        rst = 1'b0;
        ovr_en = 1'b0;
    endtask

    // ----------------------------------------------------------------------
    // Hand-written sequences
    // ----------------------------------------------------------------------
    task automatic seq_dma_drop();
        int acks;
        int at_k;
        acks = 0;
        at_k = -1;
        reset_all();
        dma_req = 1'b1; dma_rw = 1'b1; dma_ad = 16'hBEEF; dma_di = 8'h00;
        @(posedge clk);              // grant edge
        #1;
        dma_req = 1'b0;              // withdrawn mid-access
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (dma_ack) begin
                acks++;
                at_k = k;
            end
        end
        check("drop ack_count", 32'(acks), 32'd1);
        check("drop ack_cycle", 32'(at_k), 32'(W + 1));
        check("drop dma_do",    32'(dma_do), 32'(mem_fn(16'hBEEF)));
        check("drop idle_cs",   32'(mem_cs), 32'd0);
    endtask

    task automatic seq_wait0();
        reset_all();
        cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_ad = 16'h00F0; cpu_di = 8'h05;
        @(posedge clk);              // grant edge N
        #1;
        check("w0 access cs",  32'(mem_cs0),    32'd1);
        check("w0 access rdy", 32'(cpu_ready0), 32'd0);
        check("w0 access ad",  32'(mem_ad0),    32'h00F0);
        check("w0 access rw",  32'(mem_rw0),    32'd1);
        @(posedge clk);
        #1;
        check("w0 done cs",    32'(mem_cs0),    32'd0);
        check("w0 done rdy",   32'(cpu_ready0), 32'd1);
        check("w0 done cpu_do", 32'(cpu_do0),   32'(mem_fn(16'h00F0)));
        check("w0 done ack",   32'(dma_ack0),   32'd0);
        cpu_cs = 1'b0;
        @(posedge clk);
        #1;
        check("w0 idle cs",    32'(mem_cs0),    32'd0);
        check("w0 idle di",    32'(mem_di0),    32'h05);
        check("w0 idle dma_do", 32'(dma_do0),   32'd0);
    endtask

    // ----------------------------------------------------------------------
    // Randomized traffic against a transaction-timing model. Each grant at
    // edge e occupies the SRAM after edges e..e+W, completes after edge e+W+1,
    // and the arbiter samples again at edge e+W+3.
    // ----------------------------------------------------------------------
    int          m_free_at;
    logic        m_active;
    logic        m_last_dma;
    int          t_start;
    logic        t_dma;
    logic        t_rw;
    logic [15:0] t_ad;
    logic [7:0]  t_di;
    logic [7:0]  e_cpu_do;
    logic [7:0]  e_dma_do;
    logic        cpu_done_prev;
    logic        dma_done_prev;

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic new_cpu();
        cpu_cs = 1'b1; cpu_rw = 1'($urandom_range(0, 1));
        cpu_ad = rand_addr(); cpu_di = 8'($urandom);
    endtask

    task automatic new_dma();
        dma_req = 1'b1; dma_rw = 1'($urandom_range(0, 1));
        dma_ad = rand_addr(); dma_di = 8'($urandom);
    endtask

    task automatic model_edge(input int c);
        logic take_cpu;
        logic take_dma;
        if (m_active && (c == t_start + int'(W) + 1) && t_rw) begin
            if (t_dma) e_dma_do = mem_fn(t_ad);
            else       e_cpu_do = mem_fn(t_ad);
        end
        if (c >= m_free_at) begin
            take_cpu = 1'b0;
            take_dma = 1'b0;
            if (cpu_cs && dma_req) begin
                if (m_last_dma) take_cpu = 1'b1;
                else            take_dma = 1'b1;
            end else if (cpu_cs) begin
                take_cpu = 1'b1;
            end else if (dma_req) begin
                take_dma = 1'b1;
            end
            if (take_cpu || take_dma) begin
                m_active   = 1'b1;
                t_start    = c;
                t_dma      = take_dma;
                t_rw       = take_dma ? dma_rw : cpu_rw;
                t_ad       = take_dma ? dma_ad : cpu_ad;
                t_di       = take_dma ? dma_di : cpu_di;
                m_last_dma = take_dma;
                m_free_at  = c + int'(W) + 3;
            end
        end
    endtask

    task automatic model_compare(input int c);
        logic in_acc;
        logic done;
        in_acc = m_active && (c >= t_start) && (c <= t_start + int'(W));
        done   = m_active && (c == t_start + int'(W) + 1);
        check($sformatf("rnd%0d mem_cs", c), 32'(mem_cs), 32'(in_acc));
        check($sformatf("rnd%0d mem_rw", c), 32'(mem_rw), 32'(in_acc ? t_rw : 1'b1));
        check($sformatf("rnd%0d mem_ad", c), 32'(mem_ad), 32'(m_active ? t_ad : 16'h0000));
        check($sformatf("rnd%0d mem_di", c), 32'(mem_di), 32'(m_active ? t_di : 8'h00));
        check($sformatf("rnd%0d cpu_ready", c), 32'(cpu_ready), 32'(!cpu_cs || (done && !t_dma)));
        check($sformatf("rnd%0d dma_ack", c), 32'(dma_ack), 32'(done && t_dma));
        check($sformatf("rnd%0d cpu_do", c), 32'(cpu_do), 32'(e_cpu_do));
        check($sformatf("rnd%0d dma_do", c), 32'(dma_do), 32'(e_dma_do));
    endtask

    task automatic run_random(input int ncyc);
        logic cpu_done_now;
        logic dma_done_now;
        reset_all();
        m_free_at = 0; m_active = 1'b0; m_last_dma = 1'b1;
        t_start = 0; t_dma = 1'b0; t_rw = 1'b1; t_ad = 16'h0; t_di = 8'h0;
        e_cpu_do = 8'h00; e_dma_do = 8'h00;
        cpu_done_prev = 1'b0; dma_done_prev = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            model_edge(c);
            #1;
            model_compare(c);
            cpu_done_now = cpu_cs && cpu_ready;
            dma_done_now = dma_ack;
            if (cpu_done_prev) begin
                if ($urandom_range(0, 9) < 7) new_cpu();
                else                          cpu_cs = 1'b0;
            end else if (!cpu_cs && ($urandom_range(0, 9) < 3)) begin
                new_cpu();
            end
            if (dma_done_prev) begin
                if ($urandom_range(0, 9) < 7) new_dma();
                else                          dma_req = 1'b0;
            end else if (!dma_req && ($urandom_range(0, 9) < 3)) begin
                new_dma();
            end
            cpu_done_prev = cpu_done_now;
            dma_done_prev = dma_done_now;
        end
        cpu_cs  = 1'b0;
        dma_req = 1'b0;
    endtask

    initial begin
        ovr_en  = 1'b0;
        ovr_val = 8'h00;
        reset_all();
        fill_table();
        run_table();
        seq_dma_drop();
        seq_wait0();
        run_random(1500);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
